// File: rtl/reg_unit_sb.sv
// -----------------------------------------------------------------------------
// reg_unit_sb : RV32I integer register file with busy scoreboard
//
// Holds NREGS architectural registers of XLEN bits. Register 0 always reads
// zero and is never busy. The file has NRD combinational read ports and one
// synchronous write port. When BYPASS is set, a write in the current cycle is
// forwarded to any read port that addresses the same register.
//
// The scoreboard keeps one busy bit per register. Decode sets the bit when it
// issues an instruction that writes that register. Writeback clears the bit.
// Hazard logic stalls on rs_busy_o. pend_cnt_o is the registered count of busy
// registers.
//
// Ports
//   clk          rising-edge clock
//   rst_i        synchronous reset, active-high; clears registers, busy bits
//                and the pending count
//   rs_addr_i    NRD read addresses, port i = rs_addr_i[i*AW +: AW]
//   rs_data_o    NRD read data,      port i = rs_data_o[i*XLEN +: XLEN]
//   rs_busy_o    per read port: the source register has an outstanding producer
//   rd_i         writeback destination register
//   data_wr_i    writeback data
//   ru_wr_i      writeback enable
//   iss_valid_i  issue strobe: marks iss_rd_i busy
//   iss_rd_i     issued destination register
//   pend_cnt_o   number of registers that are currently busy
// -----------------------------------------------------------------------------
module reg_unit_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic [AW-1:0]       rd_i,
  input  logic [XLEN-1:0]     data_wr_i,
  input  logic                ru_wr_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic [AW:0]         pend_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;

  // A writeback to x0 is discarded. It does not touch the data or the scoreboard.
  logic wr_en;
  assign wr_en = ru_wr_i && (rd_i != '0);

  // ---------------------------------------------------------------------------
  // Scoreboard next state. If an issue and a writeback hit the same register on
  // one edge, the busy bit stays set: the newly issued producer supersedes the
  // one that is completing now.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: give every combinational output a default value first, so that no
    //       path leaves it unassigned and infers a latch.
    busy_d     = '0;
    pend_cnt_d = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_d[r] = (iss_valid_i && (iss_rd_i == AW'(r))) ||
                  (busy_q[r] && !(wr_en && (rd_i == AW'(r))));
    end
    // The count is a population count of the next busy vector. It can reach
    // at most NREGS-1, so the AW+1 bit width never wraps.
    for (int r = 0; r < NREGS; r++) begin
      pend_cnt_d = pend_cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    //       register samples the values that were present before the edge.
    if (rst_i) begin
      // NOTE: the register array is cleared on reset on purpose. The core
      //       depends on every architectural register reading zero after
      //       reset. This rules out a plain RAM macro without a reset.
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[rd_i] <= data_wr_i;
      end
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt_o = pend_cnt_q;

  // ---------------------------------------------------------------------------
  // Read ports. regs_q[0] is cleared on reset and never written, and busy_q[0]
  // is never set. So x0 needs no special case here.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          fwd;
    assign addr = rs_addr_i[i*AW +: AW];
    assign fwd  = BYPASS && wr_en && (addr == rd_i);
    // A forwarded value is the completing producer's result, so the source
    // register is no longer reported busy.
    assign rs_data_o[i*XLEN +: XLEN] = fwd ? data_wr_i : regs_q[addr];
    assign rs_busy_o[i]              = fwd ? 1'b0      : busy_q[addr];
  end

endmodule

// File: tb/tb_reg_unit_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_unit_sb : directed testbench for reg_unit_sb
//
// Two instances share every input: dut_a uses BYPASS=1 and dut_b uses
// BYPASS=0. Inputs change on the falling edge. The outputs are sampled 1 ns
// later, before the next rising edge, so forwarded values are visible.
// pend_cnt shows the state left by the earlier edges.
// -----------------------------------------------------------------------------
module tb_reg_unit_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data_a, rs_data_b;
  logic [NRD-1:0]      rs_busy_a, rs_busy_b;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     data_wr;
  logic                ru_wr;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [AW:0]         pend_cnt_a, pend_cnt_b;

  always #5 clk = ~clk;

  reg_unit_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data_a),
    .rs_busy_o(rs_busy_a), .rd_i(rd), .data_wr_i(data_wr), .ru_wr_i(ru_wr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .pend_cnt_o(pend_cnt_a)
  );

  reg_unit_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data_b),
    .rs_busy_o(rs_busy_b), .rd_i(rd), .data_wr_i(data_wr), .ru_wr_i(ru_wr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .pend_cnt_o(pend_cnt_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vector holds the inputs for one cycle and the outputs expected just
  // before that cycle's rising edge. The outputs are from the BYPASS=1 instance.
  typedef struct {
    logic          rst;
    logic          wr;
    logic [AW-1:0] rd;
    logic [31:0]   data;
    logic          iss;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] a0, a1;
    logic [31:0]   e_d0, e_d1;
    logic          e_b0, e_b1;
    logic [AW:0]   e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, int d_rd, logic [31:0] d, logic i, int i_rd,
                              int a0, int a1, logic [31:0] d0, logic [31:0] d1,
                              logic b0, logic b1, int cnt);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = AW'(d_rd); v.data = d; v.iss = i; v.iss_rd = AW'(i_rd);
    v.a0 = AW'(a0); v.a1 = AW'(a1); v.e_d0 = d0; v.e_d1 = d1;
    v.e_b0 = b0; v.e_b1 = b1; v.e_cnt = (AW+1)'(cnt);
    return v;
  endfunction

  task automatic drive(input logic r, input logic w, input int d_rd, input logic [31:0] d,
                       input logic i, input int i_rd, input int a0, input int a1);
    rst = r; ru_wr = w; rd = AW'(d_rd); data_wr = d;
    iss_valid = i; iss_rd = AW'(i_rd); rs_addr = {AW'(a1), AW'(a0)};
  endtask

  vec_t vecs[$];

  initial begin
    //              rst wr rd data          iss ird a0 a1  e_d0          e_d1          b0 b1 cnt
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  5, 0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 32'hAABBCCDD, 0, 0,  5, 0,  32'hAABBCCDD, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  5, 0,  32'hAABBCCDD, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 7, 32'h12345678, 0, 0,  7, 5,  32'h12345678, 32'hAABBCCDD, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 1, 0,  0, 7,  32'h0,        32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 3,  0, 7,  32'h0,        32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 4,  3, 4,  32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 3, 32'h33,       0, 0,  3, 4,  32'h33,       32'h0,        0, 1, 2));
    vecs.push_back(mk(0, 1, 4, 32'h44,       1, 4,  3, 4,  32'h33,       32'h44,       0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  3, 4,  32'h33,       32'h44,       0, 1, 1));
    vecs.push_back(mk(0, 0, 10, 32'h12345678, 0, 0, 10, 4, 32'h0,        32'h44,       0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 10, 4,  32'h0,        32'h44,       0, 1, 1));
    vecs.push_back(mk(0, 1, 9, 32'h99,       0, 0,  9, 4,  32'h99,       32'h44,       0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  9, 9,  32'h99,       32'h99,       0, 0, 1));
    vecs.push_back(mk(0, 1, 4, 32'h4444,     0, 0,  4, 4,  32'h4444,     32'h4444,     0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  4, 0,  32'h4444,     32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 6,  6, 0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 6,  6, 0,  32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  6, 0,  32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(1, 1, 5, 32'h55,       1, 5,  5, 6,  32'h55,       32'h0,        0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  5, 6,  32'h0,        32'h0,        0, 0, 0));

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Reset after arbitrary writes and issues.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(0, 1, $urandom_range(1, NREGS-1), $urandom, 1, $urandom_range(1, NREGS-1), 0, 0);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < NREGS; r++) begin
      rs_addr = {AW'(r), AW'(r)};
      #1;
      check($sformatf("rst.x%0d.data", r), {rs_data_a[31:0], rs_data_b[31:0]}, 64'h0);
      check($sformatf("rst.x%0d.busy", r), {rs_busy_a, rs_busy_b}, 64'h0);
    end
    check("rst.pend_cnt", {pend_cnt_a, pend_cnt_b}, 64'h0);

    // Apply the vector table.
    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].rst, vecs[n].wr, vecs[n].rd, vecs[n].data, vecs[n].iss, vecs[n].iss_rd,
            vecs[n].a0, vecs[n].a1);
      #1;
      check($sformatf("v%0d.d0", n), rs_data_a[31:0], vecs[n].e_d0);
      check($sformatf("v%0d.d1", n), rs_data_a[63:32], vecs[n].e_d1);
      check($sformatf("v%0d.busy", n), rs_busy_a, {vecs[n].e_b1, vecs[n].e_b0});
      check($sformatf("v%0d.cnt", n), pend_cnt_a, vecs[n].e_cnt);
    end

    // BYPASS=0 versus BYPASS=1. x7 is zero after reset. Issue x7, then write x7
    // and read it in the same cycle.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 7, 7, 0);
    @(negedge clk);
    drive(0, 1, 7, 32'hCAFEF00D, 0, 0, 7, 0);
    #1;
    check("byp1.data", rs_data_a[31:0], 32'hCAFEF00D);
    check("byp0.data", rs_data_b[31:0], 32'h0);
    check("byp1.busy", rs_busy_a[0], 1'b0);
    check("byp0.busy", rs_busy_b[0], 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    #1;
    check("byp0.after", rs_data_b, {32'hCAFEF00D, 32'hCAFEF00D});
    check("byp0.cnt", pend_cnt_b, 6'd0);

    // Fill the scoreboard. The count should saturate at NREGS-1, and an issue
    // to x0 must not change it.
    for (int r = 1; r < NREGS; r++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, r, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 31, 0);
    #1;
    check("full.cnt", pend_cnt_a, 6'd31);
    check("full.busy", rs_busy_a, 2'b01);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("full.cnt_x0", pend_cnt_a, 6'd31);
    check("full.busy_x0", rs_busy_a, 2'b10);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("full.reset_cnt", pend_cnt_a, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
